// File: rtl/free_list.sv
// free_list: circular free list of physical registers for a rename stage.
// Ports: clock, reset (sync, active-low), alloc_req/alloc_gnt/alloc_idx,
//   retire_en/retire_old_idx, squash, free_count, empty.
// Macro FREELIST_BYPASS_EN: registers freed by retire are allocatable
//   in the same cycle; undefined means they wait one cycle.
`ifndef WAYS
`define WAYS 4
`endif
`ifndef PRF
`define PRF 64
`endif

module free_list #(
  parameter int WAYS = `WAYS,
  parameter int PRF  = `PRF,
  parameter int ARCH = 32,
  localparam int IW  = $clog2(PRF),
  localparam int CW  = IW + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WAYS-1:0]          alloc_req,
  output logic                     alloc_gnt,
  output logic [WAYS-1:0][IW-1:0]  alloc_idx,
  input  logic [WAYS-1:0]          retire_en,
  input  logic [WAYS-1:0][IW-1:0]  retire_old_idx,
  input  logic                     squash,
  output logic [IW:0]              free_count,
  output logic                     empty
);

  logic [IW-1:0] buf_q [PRF];
  logic [IW:0]   head_q, head_d;
  logic [IW:0]   tail_q, tail_d;
  logic [IW:0]   rhead_q, rhead_d;
  logic [IW:0]   n_req, n_ret, avail;
  logic [IW-1:0] wpos [WAYS];

  assign free_count = tail_q - head_q;
  assign empty      = (free_count == '0);

  // Request/retire counts; wpos[i] is the slot retire lane i writes,
  // i.e. tail plus the number of lower retiring lanes.
  always_comb begin
    n_req = '0;
    n_ret = '0;
    for (int i = 0; i < WAYS; i++) begin
      wpos[i] = tail_q[IW-1:0] + n_ret[IW-1:0];
      n_req   = n_req + CW'(alloc_req[i]);
      n_ret   = n_ret + CW'(retire_en[i]);
    end
  end

`ifdef FREELIST_BYPASS_EN
  assign avail = free_count + n_ret;
`else
  assign avail = free_count;
`endif

  assign alloc_gnt = reset && !squash && (n_req <= avail);

  // k-th requesting lane reads buf[head+k]; with bypass, slots at or
  // beyond tail come straight from this cycle's retire lanes.
  always_comb begin
    logic [IW:0] k;
`ifdef FREELIST_BYPASS_EN
    logic [IW:0] m;
    m = '0;
`endif
    k = '0;
    for (int i = 0; i < WAYS; i++) begin
      alloc_idx[i] = '0;
      if (alloc_req[i]) begin
        alloc_idx[i] = buf_q[head_q[IW-1:0] + k[IW-1:0]];
`ifdef FREELIST_BYPASS_EN
        if (k >= free_count) begin
          m = '0;
          for (int l = 0; l < WAYS; l++) begin
            if (retire_en[l]) begin
              if (m == k - free_count)
                alloc_idx[i] = retire_old_idx[l];
              m = m + CW'(1);
            end
          end
        end
`endif
        k = k + CW'(1);
      end
    end
  end

  // Squash rewinds head to the retired point, including this
  // cycle's retires.
  always_comb begin
    tail_d  = tail_q + n_ret;
    rhead_d = rhead_q + n_ret;
    head_d  = head_q;
    if (squash)
      head_d = rhead_d;
    else if (alloc_gnt)
      head_d = head_q + n_req;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= CW'(PRF - ARCH);
      for (int k = 0; k < PRF; k++)
        buf_q[k] <= (k < PRF - ARCH) ? IW'(ARCH + k) : '0;
    end else begin
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      for (int i = 0; i < WAYS; i++)
        if (retire_en[i])
          buf_q[wpos[i]] <= retire_old_idx[i];
    end
  end

  // p0 is hard-wired and must never come back to the list.
  for (genvar g = 0; g < WAYS; g++) begin : g_p0
    a_no_p0: assert property (
      @(posedge clock) disable iff (!reset)
      retire_en[g] |-> (retire_old_idx[g] != '0));
  end

endmodule
